// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: ALU opcodes, branch funct3 codes, bsr bit layout and branch decision helper
package ex_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND, ALU_SRA
  } alu_op_t;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam int BSR_EQ  = 0;
  localparam int BSR_LT  = 1;
  localparam int BSR_LTU = 2;
  function automatic logic br_taken(input logic [2:0] f3, input logic [2:0] bsr);
    return f3 == F3_BEQ  ?  bsr[BSR_EQ]  :
           f3 == F3_BNE  ? !bsr[BSR_EQ]  :
           f3 == F3_BLT  ?  bsr[BSR_LT]  :
           f3 == F3_BGE  ? !bsr[BSR_LT]  :
           f3 == F3_BLTU ?  bsr[BSR_LTU] :
           f3 == F3_BGEU ? !bsr[BSR_LTU] : 1'b0;
  endfunction
endpackage

// File: rtl/ex_stage_alu.sv
// alu: RV32I integer ALU with compare status {ltu, lt, eq} for branch resolution
module alu
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       bsr
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];
  assign bsr[BSR_EQ]  = a == b;
  assign bsr[BSR_LT]  = $signed(a) < $signed(b);
  assign bsr[BSR_LTU] = a < b;
  // operation select; unused opcodes yield zero
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = {{(WIDTH-1){1'b0}}, bsr[BSR_LT]};
      ALU_SLTU: y = {{(WIDTH-1){1'b0}}, bsr[BSR_LTU]};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_SRA:  y = WIDTH'($signed(a) >>> sh);
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with self-bypass, branch/jump resolution and registered valid/ready output
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [XLEN-1:0] id_rs2_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic            id_use_imm_i,
  input  logic            id_use_pc_i,
  input  logic [3:0]      id_alu_op_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_we_i,
  input  logic            id_br_i,
  input  logic [2:0]      id_br_funct3_i,
  input  logic            id_jal_i,
  input  logic            id_jalr_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_result_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic            ex_rd_we_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);
  logic            accept, fwd_ok, jump, taken;
  logic [XLEN-1:0] rs1_v, rs2_v, op_a, op_b, alu_y, result, target;
  logic [2:0]      bsr;
  alu_op_t         op;
  assign id_ready_o = !ex_valid_o || ex_ready_i;
  assign accept     = id_valid_i && id_ready_o && !flush_i;
  assign fwd_ok     = ex_valid_o && ex_rd_we_o && ex_rd_addr_o != 5'd0;
  assign rs1_v      = fwd_ok && id_rs1_addr_i == ex_rd_addr_o ? ex_result_o : id_rs1_i;
  assign rs2_v      = fwd_ok && id_rs2_addr_i == ex_rd_addr_o ? ex_result_o : id_rs2_i;
  assign op_a       = id_br_i ? rs1_v : id_use_pc_i ? id_pc_i : rs1_v;
  assign op_b       = id_br_i ? rs2_v : id_use_imm_i ? id_imm_i : rs2_v;
  assign op         = id_br_i ? ALU_SUB : alu_op_t'(id_alu_op_i);
  assign jump       = id_jal_i || id_jalr_i;
  assign result     = jump ? id_pc_i + XLEN'(4) : alu_y;
  assign target     = id_jalr_i ? (rs1_v + id_imm_i) & ~XLEN'(1) : id_pc_i + id_imm_i;
  assign taken      = jump || (id_br_i && br_taken(id_br_funct3_i, bsr));
  alu #(.WIDTH(XLEN)) u_alu (.a(op_a), .b(op_b), .op(op), .y(alu_y), .bsr(bsr));
  // result register: capture on accept, drain when consumed, kill on flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid_o   <= 1'b0;
      ex_result_o  <= '0;
      ex_rd_addr_o <= '0;
      ex_rd_we_o   <= 1'b0;
      ex_pc_o      <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (accept) begin
      ex_valid_o   <= 1'b1;
      ex_result_o  <= result;
      ex_rd_addr_o <= id_rd_addr_i;
      ex_rd_we_o   <= id_rd_we_i && id_rd_addr_i != 5'd0 && !id_br_i;
      ex_pc_o      <= id_pc_i;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  // redirect pulses only in the cycle after a taken accept, never while stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      redirect_o <= accept && taken;
      if (accept) redirect_pc_o <= target;
    end
endmodule
